// File: rtl/llc_req_arbiter_pkg.sv
// LLC_defs: shared defaults and FSM state encoding for the LLC request arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package LLC_defs;

  localparam int NUM_REQ_DEF     = 4;
  localparam int LLC_LATENCY_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/llc_req_arbiter_rr_arbiter.sv
// rr_arbiter: rotating-priority pick of the first set req bit at or after ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; grant is one-hot, or zero when req is zero.
//
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index with highest priority this cycle
//   grant - one-hot winner (all-zero when no request)
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW-1:0] idx;
  logic          found;

  // N is a power of two, so the PW-bit sum wraps modulo N for free.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + PW'(i);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/llc_req_arbiter.sv
// llc_req_arbiter: shares one LLC port among NUM_REQ requesters, one transaction at a time.
// Latency: accept T, llc_cs T+1, rsp_valid T+2+LLC_LATENCY, next accept T+3+LLC_LATENCY.
// Backpressure: req_ready is all-zero while busy; an unaccepted request may be withdrawn freely.
//
// Ports:
//   clk, reset                         - clock, async active-low reset
//   req_valid/req_ready                - per-requester handshake (ready one-hot or zero)
//   req_addr/req_wr/req_wdata          - per-requester request fields
//   rsp_valid/rsp_hit/rsp_rdata        - one-hot response strobe plus shared result
//   llc_cs/llc_wr/llc_addr/llc_data_in - LLC request side
//   llc_hit/llc_data_out               - LLC result, valid LLC_LATENCY cycles after llc_cs
//   busy, grant_id                     - status: not IDLE, last accepted requester
module llc_req_arbiter
  import LLC_defs::*;
#(
  parameter  int NUM_REQ     = NUM_REQ_DEF,
  parameter  int LLC_LATENCY = LLC_LATENCY_DEF,
  localparam int IW          = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0][31:0]  req_addr,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ-1:0][7:0]   req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_hit,
  output logic [7:0]                rsp_rdata,
  output logic                      llc_cs,
  output logic                      llc_wr,
  output logic [31:0]               llc_addr,
  output logic [7:0]                llc_data_in,
  input  logic                      llc_hit,
  input  logic [7:0]                llc_data_out,
  output logic                      busy,
  output logic [IW-1:0]             grant_id
);

  state_t               state;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        gid_q;
  logic [2:0]           wait_cnt;
  logic [31:0]          addr_q;
  logic                 wr_q;
  logic [7:0]           wdata_q;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 accept;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) arb_idx = IW'(i);
    end
  end

  // Gating with reset keeps ready low while reset is held, even though the
  // arbiter itself is combinational on req_valid.
  assign req_ready   = (reset && state == ST_IDLE) ? arb_grant : '0;
  assign accept      = |(req_valid & req_ready);
  assign busy        = (state != ST_IDLE);
  assign llc_cs      = (state == ST_ISSUE);
  assign llc_wr      = llc_cs & wr_q;
  assign llc_addr    = addr_q;
  assign llc_data_in = wdata_q;
  assign grant_id    = gid_q;

  always_comb begin
    rsp_valid = '0;
    if (state == ST_RESP) rsp_valid[gid_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      gid_q     <= '0;
      wait_cnt  <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rsp_hit   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= req_addr[arb_idx];
            wr_q    <= req_wr[arb_idx];
            wdata_q <= req_wdata[arb_idx];
            gid_q   <= arb_idx;
            rr_ptr  <= arb_idx + 1'b1;  // wraps modulo NUM_REQ
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Count down to zero so WAIT spans exactly LLC_LATENCY cycles.
          wait_cnt <= 3'(LLC_LATENCY - 1);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == 3'd0) begin
            rsp_hit   <= llc_hit;
            rsp_rdata <= llc_data_out;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_llc_req_arbiter.sv
// Bench for llc_req_arbiter: four instances (LLC_LATENCY 1,3,4,7) share stimulus.
// A transaction-level timing model checks every instance every cycle; directed
// table and sequences check the named scenarios with hand-derived constants.
module tb_llc_req_arbiter;

  logic             clk;
  logic             reset;
  logic [3:0]       req_valid;
  logic [3:0]       req_wr;
  logic [3:0][31:0] req_addr;
  logic [3:0][7:0]  req_wdata;
  logic             llc_hit;
  logic [7:0]       llc_data_out;

  logic [3:0]  rdy_o  [4];
  logic [3:0]  rspv_o [4];
  logic        hit_o  [4];
  logic [7:0]  rd_o   [4];
  logic        cs_o   [4];
  logic        wr_o   [4];
  logic [31:0] addr_o [4];
  logic [7:0]  din_o  [4];
  logic        busy_o [4];
  logic [1:0]  gid_o  [4];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit llc_rand = 0;
  int last_rsp [4];

  for (genvar k = 0; k < 4; k++) begin : g_dut
    llc_req_arbiter #(
      .NUM_REQ     (4),
      .LLC_LATENCY (k == 0 ? 1 : k == 1 ? 3 : k == 2 ? 4 : 7)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (rdy_o[k]),
      .req_addr     (req_addr),
      .req_wr       (req_wr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rspv_o[k]),
      .rsp_hit      (hit_o[k]),
      .rsp_rdata    (rd_o[k]),
      .llc_cs       (cs_o[k]),
      .llc_wr       (wr_o[k]),
      .llc_addr     (addr_o[k]),
      .llc_data_in  (din_o[k]),
      .llc_hit      (llc_hit),
      .llc_data_out (llc_data_out),
      .busy         (busy_o[k]),
      .grant_id     (gid_o[k])
    );
  end

  function automatic int lat(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      default: return 7;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // LLC result changes every cycle in random mode so a capture on the wrong
  // cycle shows up as a data mismatch.
  always @(posedge clk) begin
    #2;
    if (llc_rand) begin
      llc_hit      = 1'($urandom);
      llc_data_out = 8'($urandom);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++)
      if (rspv_o[k] != 4'd0) last_rsp[k] = cyc;
  end

  // ---------------- reference model ----------------
  // Each instance is either idle or owns one transaction accepted at cycle
  // m_t; everything else follows from the cycle offset relative to m_t.
  bit          m_out   [4];
  int          m_t     [4];
  int          m_g     [4];
  int          m_ptr   [4];
  logic [31:0] m_a     [4];
  logic        m_w     [4];
  logic [7:0]  m_d     [4];
  logic        m_hit   [4];
  logic [7:0]  m_rd    [4];
  bit          m_rd_ok [4];
  logic [1:0]  m_gid   [4];

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      int c;
      int L;
      int g;
      c = cyc;
      L = lat(k);
      if (!reset) begin
        chk($sformatf("m%0d.rst.ready", k), rdy_o[k], 4'd0);
        chk($sformatf("m%0d.rst.rspv", k), rspv_o[k], 4'd0);
        chk($sformatf("m%0d.rst.hit", k), hit_o[k], 1'b0);
        chk($sformatf("m%0d.rst.rdata", k), rd_o[k], 8'd0);
        chk($sformatf("m%0d.rst.busy", k), busy_o[k], 1'b0);
        chk($sformatf("m%0d.rst.gid", k), gid_o[k], 2'd0);
        chk($sformatf("m%0d.rst.cs", k), cs_o[k], 1'b0);
        chk($sformatf("m%0d.rst.wr", k), wr_o[k], 1'b0);
        chk($sformatf("m%0d.rst.addr", k), addr_o[k], 32'd0);
        chk($sformatf("m%0d.rst.din", k), din_o[k], 8'd0);
        m_out[k]   = 1'b0;
        m_ptr[k]   = 0;
        m_hit[k]   = 1'b0;
        m_rd[k]    = 8'd0;
        m_rd_ok[k] = 1'b1;
        m_gid[k]   = 2'd0;
      end else begin
        if (m_out[k] && c == m_t[k] + 3 + L) m_out[k] = 1'b0;
        chk($sformatf("m%0d.gid", k), gid_o[k], m_gid[k]);
        chk($sformatf("m%0d.hit", k), hit_o[k], m_hit[k]);
        if (m_rd_ok[k]) chk($sformatf("m%0d.rdata", k), rd_o[k], m_rd[k]);
        if (m_out[k]) begin
          chk($sformatf("m%0d.ready", k), rdy_o[k], 4'd0);
          chk($sformatf("m%0d.busy", k), busy_o[k], 1'b1);
          chk($sformatf("m%0d.cs", k), cs_o[k], c == m_t[k] + 1);
          chk($sformatf("m%0d.rspv", k), rspv_o[k],
              (c == m_t[k] + 2 + L) ? 4'(1 << m_g[k]) : 4'd0);
          if (c == m_t[k] + 1) begin
            chk($sformatf("m%0d.addr", k), addr_o[k], m_a[k]);
            chk($sformatf("m%0d.llcwr", k), wr_o[k], m_w[k]);
            if (m_w[k]) chk($sformatf("m%0d.din", k), din_o[k], m_d[k]);
          end
          if (c == m_t[k] + 1 + L) begin
            m_hit[k]   = llc_hit;
            m_rd[k]    = llc_data_out;
            m_rd_ok[k] = !m_w[k];
          end
        end else begin
          g = -1;
          for (int i = 0; i < 4; i++)
            if (g < 0 && req_valid[(m_ptr[k] + i) % 4]) g = (m_ptr[k] + i) % 4;
          chk($sformatf("m%0d.ready", k), rdy_o[k], (g < 0) ? 4'd0 : 4'(1 << g));
          chk($sformatf("m%0d.busy", k), busy_o[k], 1'b0);
          chk($sformatf("m%0d.cs", k), cs_o[k], 1'b0);
          chk($sformatf("m%0d.rspv", k), rspv_o[k], 4'd0);
          if (g >= 0) begin
            m_out[k] = 1'b1;
            m_t[k]   = c;
            m_g[k]   = g;
            m_ptr[k] = (g + 1) % 4;
            m_a[k]   = req_addr[g];
            m_w[k]   = req_wr[g];
            m_d[k]   = req_wdata[g];
            m_gid[k] = 2'(g);
          end
        end
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  typedef struct {
    logic [3:0] vld;
    logic [3:0] exp_rdy;
    logic [1:0] exp_gid;
  } vec_t;

  vec_t tbl [10];
  int   gidx [5];
  int   gcyc [5];
  int   exp_order [5];
  int   n;
  int   t0;

  initial begin
    // Rotating priority from rr_ptr=0, one single-cycle request per entry.
    tbl[0] = '{4'b0000, 4'b0000, 2'd0};
    tbl[1] = '{4'b1010, 4'b0010, 2'd1};
    tbl[2] = '{4'b0011, 4'b0001, 2'd0};
    tbl[3] = '{4'b1100, 4'b0100, 2'd2};
    tbl[4] = '{4'b0101, 4'b0001, 2'd0};
    tbl[5] = '{4'b0000, 4'b0000, 2'd0};
    tbl[6] = '{4'b1001, 4'b1000, 2'd3};
    tbl[7] = '{4'b1111, 4'b0001, 2'd0};
    tbl[8] = '{4'b0001, 4'b0001, 2'd0};
    tbl[9] = '{4'b1000, 4'b1000, 2'd3};
    exp_order = '{0, 1, 2, 3, 0};

    reset        = 1'b0;
    req_valid    = 4'hF;
    req_wr       = 4'h0;
    req_addr     = '0;
    req_wdata    = '0;
    llc_hit      = 1'b0;
    llc_data_out = 8'd0;
    for (int k = 0; k < 4; k++) last_rsp[k] = -1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.ready_with_valid", rdy_o[0], 4'd0);
    chk("reset.busy", busy_o[0], 1'b0);
    chk("reset.cs", cs_o[0], 1'b0);
    step();
    reset     = 1'b1;
    req_valid = 4'h0;

    // Table-driven rotating priority.
    for (int i = 0; i < 10; i++) begin
      step();
      req_valid = tbl[i].vld;
      @(negedge clk);
      chk($sformatf("tbl%0d.ready", i), rdy_o[0], tbl[i].exp_rdy);
      step();
      req_valid = 4'h0;
      @(negedge clk);
      if (tbl[i].exp_rdy != 4'd0) chk($sformatf("tbl%0d.gid", i), gid_o[0], tbl[i].exp_gid);
      repeat (10) step();
    end

    // Single read from requester 2 right after reset; latency sweep over instances.
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    for (int k = 0; k < 4; k++) last_rsp[k] = -1;
    req_valid    = 4'b0100;
    req_addr[2]  = 32'h0010_0045;
    req_wr       = 4'h0;
    llc_hit      = 1'b1;
    llc_data_out = 8'hA5;
    @(negedge clk);
    t0 = cyc;
    chk("read.ready", rdy_o[0], 4'b0100);
    step();
    req_valid = 4'h0;
    @(negedge clk);
    chk("read.cs_t1", cs_o[0], 1'b1);
    chk("read.addr", addr_o[0], 32'h0010_0045);
    step();
    @(negedge clk);
    chk("read.cs_t2", cs_o[0], 1'b0);
    chk("read.rspv_t2", rspv_o[0], 4'd0);
    step();
    @(negedge clk);
    chk("read.rspv_t3", rspv_o[0], 4'b0100);
    chk("read.rdata", rd_o[0], 8'hA5);
    chk("read.hit", hit_o[0], 1'b1);
    step();
    @(negedge clk);
    chk("read.rspv_t4", rspv_o[0], 4'd0);
    chk("read.rdata_hold", rd_o[0], 8'hA5);
    repeat (10) step();
    for (int k = 0; k < 4; k++)
      chk($sformatf("sweep.L%0d.rsp_cycle", lat(k)), last_rsp[k], t0 + 2 + lat(k));

    // All four held valid: grant order and spacing on the LLC_LATENCY=1 instance.
    reset = 1'b0;
    step();
    reset     = 1'b1;
    req_valid = 4'hF;
    n = 0;
    for (int i = 0; i < 40 && n < 5; i++) begin
      @(negedge clk);
      if (rdy_o[0] != 4'd0) begin
        for (int j = 0; j < 4; j++) if (rdy_o[0][j]) gidx[n] = j;
        gcyc[n] = cyc;
        n++;
      end
      step();
    end
    req_valid = 4'h0;
    chk("rr.grant_count", n, 5);
    for (int i = 0; i < n; i++) chk($sformatf("rr.order%0d", i), gidx[i], exp_order[i]);
    for (int i = 1; i < n; i++) chk($sformatf("rr.spacing%0d", i), gcyc[i] - gcyc[i-1], 4);
    repeat (12) step();

    // Requester 1 waits out a busy period, then is accepted.
    req_valid = 4'b0001;
    @(negedge clk);
    chk("busy.first_ready", rdy_o[0], 4'b0001);
    step();
    req_valid = 4'b0010;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      chk($sformatf("busy.ready_t%0d", j), rdy_o[0], 4'd0);
      chk($sformatf("busy.busy_t%0d", j), busy_o[0], 1'b1);
      step();
    end
    @(negedge clk);
    chk("busy.ready_t4", rdy_o[0], 4'b0010);
    step();
    req_valid = 4'h0;
    repeat (12) step();

    // Write miss from requester 3.
    req_valid    = 4'b1000;
    req_wr       = 4'b1000;
    req_wdata[3] = 8'h5A;
    llc_hit      = 1'b0;
    llc_data_out = 8'hFF;
    @(negedge clk);
    chk("wr.ready", rdy_o[0], 4'b1000);
    step();
    req_valid = 4'h0;
    @(negedge clk);
    chk("wr.cs", cs_o[0], 1'b1);
    chk("wr.llc_wr", wr_o[0], 1'b1);
    chk("wr.din", din_o[0], 8'h5A);
    step();
    step();
    @(negedge clk);
    chk("wr.rspv", rspv_o[0], 4'b1000);
    chk("wr.hit", hit_o[0], 1'b0);
    req_wr = 4'h0;
    repeat (12) step();

    // Reset in the middle of WAIT on the LLC_LATENCY=3 instance.
    last_rsp[1] = -1;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("abort.ready", rdy_o[1], 4'b0100);
    step();
    req_valid = 4'h0;
    step();
    reset = 1'b0;
    #1;
    chk("abort.busy", busy_o[1], 1'b0);
    chk("abort.cs", cs_o[1], 1'b0);
    chk("abort.addr", addr_o[1], 32'd0);
    chk("abort.gid", gid_o[1], 2'd0);
    step();
    step();
    reset = 1'b1;
    repeat (4) step();
    chk("abort.no_rsp", last_rsp[1], -1);
    req_valid = 4'hF;
    @(negedge clk);
    chk("abort.next_grant", rdy_o[1], 4'b0001);
    step();
    req_valid = 4'h0;
    repeat (12) step();

    // Random traffic: withdrawn requests, mixed read/write, occasional reset.
    llc_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      step();
      reset = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) req_valid = 4'($urandom);
      req_wr = 4'($urandom);
      for (int j = 0; j < 4; j++) begin
        req_addr[j]  = $urandom;
        req_wdata[j] = 8'($urandom);
      end
    end
    reset     = 1'b1;
    req_valid = 4'h0;
    repeat (12) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/llc_req_arbiter.md
LLC_REQ_ARBITER -- requirements
Module: llc_req_arbiter

Interface
REQ-001 Clock and reset SHALL be one clock and an asynchronous, active-low reset: port clk is the single clock, port reset is the reset, asserted at 0.
REQ-002 Parameter NUM_REQ, default 4: number of requesters sharing the LLC port; legal values 2, 4, 8.
REQ-003 Parameter LLC_LATENCY, default 1: cycles from the cycle llc_cs is high to the cycle llc_hit/llc_data_out are valid; legal range 1..7.
REQ-004 clk  in  1  system clock, rising-edge active.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester request valid.
REQ-007 req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
REQ-008 req_addr  in  NUM_REQ x 32  per-requester byte address.
REQ-009 req_wr  in  NUM_REQ  per-requester write (1) / read (0).
REQ-010 req_wdata  in  NUM_REQ x 8  per-requester write byte.
REQ-011 rsp_valid  out  NUM_REQ  one-hot response strobe to the originating requester.
REQ-012 rsp_hit  out  1  hit result, shared by all requesters.
REQ-013 rsp_rdata  out  8  read byte, shared by all requesters.
REQ-014 llc_cs, llc_wr  out  1 each  LLC chip-select and write.
REQ-015 llc_addr  out  32  and  llc_data_in  out  8  LLC request address and write byte.
REQ-016 llc_hit  in  1  and  llc_data_out  in  8  LLC result.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 grant_id  out  log2(NUM_REQ)  index of the current or last accepted requester.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-020 In IDLE with any req_valid high, req_ready SHALL be asserted combinationally for exactly one requester: the first valid at or after rr_ptr, in ascending index order, wrapping modulo NUM_REQ.
REQ-021 Accept SHALL occur when req_valid and req_ready are both high; addr, wr, wdata and the index are then registered, rr_ptr becomes (index+1) mod NUM_REQ, and the FSM goes to ISSUE.
REQ-022 In IDLE with no valid requester, the FSM SHALL stay in IDLE and rr_ptr SHALL be unchanged.
REQ-023 ISSUE SHALL last exactly 1 cycle, with llc_cs=1 and the registered address, wr and write byte on llc_addr, llc_wr and llc_data_in; the FSM then goes to WAIT.
REQ-024 llc_cs SHALL be 0 in every state other than ISSUE.
REQ-025 WAIT SHALL last LLC_LATENCY cycles, counted by a 3-bit down-counter.
REQ-026 On the last WAIT cycle, llc_hit and llc_data_out SHALL be captured into rsp_hit and rsp_rdata, and the FSM goes to RESP.
REQ-027 RESP SHALL last 1 cycle with rsp_valid[grant_id]=1, then return to IDLE.
REQ-028 Latency SHALL be: accept in cycle T, llc_cs in T+1, rsp_valid in T+2+LLC_LATENCY, next accept possible in T+3+LLC_LATENCY.
REQ-029 req_ready SHALL be all-zero whenever busy=1, so that at most one transaction is outstanding.
REQ-030 A requester that drops req_valid before accept SHALL forfeit its request, and no state change SHALL result.
REQ-031 rsp_hit and rsp_rdata SHALL hold their last captured values outside RESP.
REQ-032 For writes, rsp_rdata is don't-care, and rsp_hit SHALL still report llc_hit.
REQ-033 Fairness: a requester held valid SHALL be accepted within NUM_REQ grants.

Reset
REQ-034 While reset=0, asynchronously: state=IDLE, rr_ptr=0, WAIT counter=0, and the registered request fields=0.
REQ-035 While reset=0, asynchronously: llc_cs=0, llc_wr=0, llc_addr=0, llc_data_in=0.
REQ-036 While reset=0, asynchronously: req_ready=0, rsp_valid=0, rsp_hit=0, rsp_rdata=0, busy=0, grant_id=0.
REQ-037 Reset asserted mid-transaction SHALL abort it: no rsp_valid is produced for it, and llc_cs drops in the same cycle.

Structure
REQ-038 NUM_REQ, LLC_LATENCY defaults and the FSM state enum SHALL live in package LLC_defs.
REQ-039 The rotating-priority selection SHALL be a sub-module rr_arbiter with ports req, ptr and grant (one-hot); it is combinational, and rr_ptr is held in llc_req_arbiter.

Verification
REQ-040 Single read: reset, requester 2 issues a read of addr 0x0010_0045 in cycle T; LLC returns hit=1, data=0xA5 -> llc_cs only in T+1 with llc_addr=0x0010_0045, rsp_valid=4'b0100 in T+3, rsp_rdata=0xA5, rsp_hit=1.
REQ-041 Round-robin: all four req_valid held high -> grant order 0,1,2,3,0, with accepts exactly 4 cycles apart (LLC_LATENCY=1).
REQ-042 Busy blocking: requester 1 is valid while busy -> req_ready stays 0 until IDLE, then requester 1 is accepted.
REQ-043 Write miss: requester 3 writes 0x5A with llc_hit=0 -> llc_wr=1, llc_data_in=0x5A in ISSUE, rsp_valid[3]=1, rsp_hit=0.
REQ-044 Reset mid-WAIT with LLC_LATENCY=3 -> outputs are 0 immediately, no rsp_valid is produced, and the next grant goes to requester 0.
REQ-045 Latency sweep with LLC_LATENCY=1, 4, 7 -> rsp_valid in T+2+LLC_LATENCY.
